// File: rtl/wrap030_bus_watchdog.sv
// Bus-cycle watchdog for a 68030-style bus.
// Each address-strobe cycle is timed from its start. A normal cycle that does not
// terminate within TIMEOUT edges gets a bus error. An interrupt-acknowledge cycle
// that does not terminate within AVEC_DELAY edges gets an autovector request.
// In both cases the strobe is held until the master drops busAS_n.
//
// Ports:
//   busClk        bus clock; all state updates on its rising edge
//   busReset_n    asynchronous active-low reset
//   busAS_n       address strobe, active-low
//   busFC         function code, sampled only at cycle start
//   busAddr       address bits 19:16, sampled only at cycle start
//   busDsack_n    data strobe acknowledge, active-low per bit
//   busSterm_n    synchronous termination, active-low
//   busBerr_nz    bus error: open-drain output (0 or Z), also read back as an input
//   busAvec_nz    autovector request: open-drain output (0 or Z)
//   timeoutCount  saturating count of bus errors issued since reset
module wrap030_bus_watchdog #(
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned AVEC_DELAY = 8
) (
    input  logic       busClk,
    input  logic       busReset_n,
    input  logic       busAS_n,
    input  logic [2:0] busFC,
    input  logic [3:0] busAddr,
    input  logic [1:0] busDsack_n,
    input  logic       busSterm_n,
    inout  wire        busBerr_nz,
    output wire        busAvec_nz,
    output logic [7:0] timeoutCount
);

    localparam logic [7:0] TIMEOUT_LIM = TIMEOUT[7:0];
    localparam logic [7:0] AVEC_LIM    = AVEC_DELAY[7:0];

    typedef enum logic [2:0] {
        sIDL  = 3'd0,
        sRUN  = 3'd1,
        sBERR = 3'd2,
        sAVEC = 3'd3,
        sHOLD = 3'd4
    } state_e;

    state_e     stateQ, stateD;
    logic [7:0] cycleCountQ, cycleCountD;
    logic       iackFlagQ, iackFlagD;
    logic [7:0] timeoutCountQ, timeoutCountD;
    logic       berrQ, berrD;
    logic       avecQ, avecD;

    logic berrIn;
    logic termination;
    logic iackCycle;

    assign berrIn = busBerr_nz;

    // Our own bus error is only driven outside sRUN, so the read-back term here
    // only ever reflects another device on the bus.
    assign termination = (busDsack_n != 2'b11) || !busSterm_n ||
                         ((stateQ == sRUN) && !berrIn);

    assign iackCycle = (busFC == 3'b111) && (busAddr == 4'hF);

    // State register
    always_ff @(posedge busClk or negedge busReset_n) begin
        if (!busReset_n) begin
            stateQ        <= sIDL;
            cycleCountQ   <= 8'd0;
            iackFlagQ     <= 1'b0;
            timeoutCountQ <= 8'd0;
            berrQ         <= 1'b0;
            avecQ         <= 1'b0;
        end else begin
            stateQ        <= stateD;
            cycleCountQ   <= cycleCountD;
            iackFlagQ     <= iackFlagD;
            timeoutCountQ <= timeoutCountD;
            berrQ         <= berrD;
            avecQ         <= avecD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD      = stateQ;
        cycleCountD = cycleCountQ;
        iackFlagD   = iackFlagQ;
        unique case (stateQ)
            sIDL: begin
                if (!busAS_n) begin
                    stateD      = sRUN;
                    cycleCountD = 8'd1;
                    iackFlagD   = iackCycle;
                end else begin
                    cycleCountD = 8'd0;
                end
            end
            sRUN: begin
                // Termination is checked before the limits so a late ack still wins.
                if (busAS_n) begin
                    stateD = sIDL;
                end else if (termination) begin
                    stateD = sHOLD;
                end else if (iackFlagQ && (cycleCountQ == AVEC_LIM)) begin
                    stateD = sAVEC;
                end else if (!iackFlagQ && (cycleCountQ == TIMEOUT_LIM)) begin
                    stateD = sBERR;
                end else begin
                    cycleCountD = cycleCountQ + 8'd1;
                end
            end
            sBERR, sAVEC, sHOLD: begin
                if (busAS_n) begin
                    stateD = sIDL;
                end
            end
            default: stateD = sIDL;
        endcase
    end

    // Output logic: strobes are registered copies of the next state, so they
    // change on the same edge as the state and can never overlap.
    always_comb begin
        berrD         = (stateD == sBERR);
        avecD         = (stateD == sAVEC);
        timeoutCountD = timeoutCountQ;
        if ((stateQ == sRUN) && (stateD == sBERR) && (timeoutCountQ != 8'hFF)) begin
            timeoutCountD = timeoutCountQ + 8'd1;
        end
    end

    assign busBerr_nz   = berrQ ? 1'b0 : 1'bz;
    assign busAvec_nz   = avecQ ? 1'b0 : 1'bz;
    assign timeoutCount = timeoutCountQ;

endmodule
